ga23_layer_ext: RTL and testbench

- Parametrised next-generation GA23 tilemap layer, one instance per playfield.
- Supports 8x8 or 16x16 tiles and a configurable SDRAM address width.
- Replaces the fire-and-forget SDRAM read with a handshaked fetch state machine and a pending/active double buffer, so a late `sdr_rdy` no longer corrupts output.
- Fine scroll uses a 16-pixel window; fetch underrun is detected and flagged.

---
 rtl/ga23_layer_ext.sv | 238 +++++++++++++++++++++++
 tb/tb_ga23_layer_ext.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ga23_layer_ext.sv
// GA23 tilemap layer: handshaked tile-row fetch, pending/active double buffer, 16-pixel fine-scroll window.
// Define GA23_LAYER_UNDERRUN_CNT_EN to add the saturating underrun_cnt output.
module ga23_layer_ext #(
    parameter int TILE_16 = 0,
    parameter int ADDR_W  = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce_pix,
    input  logic              load,
    input  logic [9:0]        x_ofs,
    input  logic [9:0]        y_ofs,
    input  logic [7:0]        control,
    input  logic [9:0]        x_base,
    input  logic [9:0]        y,
    input  logic [9:0]        rowscroll,
    output logic [14:0]       vram_addr,
    input  logic [15:0]       attrib,
    input  logic [15:0]       index,
    output logic [ADDR_W-1:0] sdr_addr,
    output logic              sdr_req,
    input  logic              sdr_rdy,
    input  logic [31:0]       sdr_data,
    output logic [10:0]       color_out,
    output logic              prio_out,
    output logic              underrun,
`ifdef GA23_LAYER_UNDERRUN_CNT_EN
    output logic [15:0]       underrun_cnt,
`endif
    input  logic              dbg_enabled
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    function automatic logic [31:0] rev_nib(input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 8; i++) r[4*i +: 4] = d[4*(7-i) +: 4];
        return r;
    endfunction

    logic [9:0]         x, yy;
    logic [6:0]         tile_x, tile_xw;
    logic [5:0]         tile_y;
    logic [3:0]         row;
    logic [12:0]        tile_ofs;
    logic [23:0]        addr_full;
    logic [ADDR_W+23:0] addr_ext;

    assign x  = x_base + (control[6] ? rowscroll : x_ofs);
    assign yy = y + y_ofs;

    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        if (TILE_16 != 0) begin
            tile_x    = {1'b0, x[9:4]};
            tile_y    = yy[9:4];
            row       = attrib[10] ? ~yy[3:0] : yy[3:0];
            addr_full = {attrib[15], index, row[3], x[3] ^ attrib[9], row[2:0], 2'b00};
        end else begin
            tile_x    = x[9:3];
            tile_y    = yy[8:3];
            row       = {1'b0, (attrib[10] ? ~yy[2:0] : yy[2:0])};
            addr_full = {2'b00, attrib[15], index, row[2:0], 2'b00};
        end
    end

    assign tile_xw   = tile_x + 7'd32;
    assign tile_ofs  = control[2] ? {tile_y, tile_xw} : {1'b0, tile_y, tile_x[5:0]};
    assign vram_addr = {control[1:0], 13'd0} + {2'b00, tile_ofs};
    assign addr_ext  = {{ADDR_W{1'b0}}, addr_full};

    // Fetch state machine and the tile attributes latched for the fetch in flight
    state_t            state, state_nx;
    logic [ADDR_W-1:0] f_addr;
    logic [6:0]        f_pal;
    logic [1:0]        f_prio;
    logic              f_flip;
    logic [2:0]        f_fine;
    logic              fire, start, got, abort, swap_under;

    assign fire  = ce_pix & load;
    assign start = fire & dbg_enabled;
    assign got   = (state == S_WAIT) & sdr_rdy;
    assign abort = start & (state != S_IDLE) & ~got;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_REQ;
            S_REQ:   state_nx = start ? S_REQ : S_WAIT;
            S_WAIT:  if (start) state_nx = S_REQ;
                     else if (sdr_rdy) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign sdr_req  = (state == S_REQ);
    assign sdr_addr = f_addr;

    logic [31:0] pend_px;
    logic [6:0]  pend_pal;
    logic [1:0]  pend_prio;
    logic [2:0]  pend_fine;
    logic        pend_valid;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            f_addr     <= '0;
            f_pal      <= '0;
            f_prio     <= '0;
            f_flip     <= 1'b0;
            f_fine     <= '0;
            pend_px    <= '0;
            pend_pal   <= '0;
            pend_prio  <= '0;
            pend_fine  <= '0;
            pend_valid <= 1'b0;
        end else begin
            state <= state_nx;
            if (start) begin
                f_addr <= addr_ext[ADDR_W-1:0];
                f_pal  <= attrib[6:0];
                f_prio <= attrib[8:7];
                f_flip <= attrib[9];
                f_fine <= x[2:0];
            end
            if (got) begin
                pend_px   <= f_flip ? rev_nib(sdr_data) : sdr_data;
                pend_pal  <= f_pal;
                pend_prio <= f_prio;
                pend_fine <= f_fine;
            end
            // A swap consumes the pending tile, including one arriving in the same clk
            if (fire)     pend_valid <= 1'b0;
            else if (got) pend_valid <= 1'b1;
        end
    end

    // Data returning in the swap clk bypasses the pending buffer
    logic [31:0] eff_px;
    logic [6:0]  eff_pal;
    logic [1:0]  eff_prio;
    logic [2:0]  eff_fine;
    logic        eff_valid;

    assign eff_valid  = pend_valid | got;
    assign eff_px     = got ? (f_flip ? rev_nib(sdr_data) : sdr_data) : pend_px;
    assign eff_pal    = got ? f_pal  : pend_pal;
    assign eff_prio   = got ? f_prio : pend_prio;
    assign eff_fine   = got ? f_fine : pend_fine;
    assign swap_under = fire & ~eff_valid;

    logic [31:0] cur_px, old_px, nx_cur_px, nx_old_px;
    logic [6:0]  cur_pal, old_pal, nx_cur_pal, nx_old_pal;
    logic [1:0]  cur_prio, old_prio, nx_cur_prio, nx_old_prio;
    logic [2:0]  fine, nx_fine, cnt, cnt_use;
    logic [3:0]  idx, pix;
    logic [63:0] win;
    logic [6:0]  pal;
    logic [1:0]  prio;
    logic        enabled;

    always_comb begin
        nx_cur_px   = cur_px;
        nx_old_px   = old_px;
        nx_cur_pal  = cur_pal;
        nx_old_pal  = old_pal;
        nx_cur_prio = cur_prio;
        nx_old_prio = old_prio;
        nx_fine     = fine;
        if (fire) begin
            nx_old_px   = cur_px;
            nx_old_pal  = cur_pal;
            nx_old_prio = cur_prio;
            nx_cur_px   = eff_valid ? eff_px   : 32'd0;
            nx_cur_pal  = eff_valid ? eff_pal  : 7'd0;
            nx_cur_prio = eff_valid ? eff_prio : 2'd0;
            nx_fine     = eff_valid ? eff_fine : 3'd0;
        end
        // Window indices 0..7 hold the previous tile, 8..15 the active one
        cnt_use = fire ? 3'd0 : cnt;
        idx     = 4'd8 + {1'b0, cnt_use} - {1'b0, nx_fine};
        win     = {nx_cur_px, nx_old_px};
        pix     = win[{idx, 2'b00} +: 4];
        pal     = idx[3] ? nx_cur_pal  : nx_old_pal;
        prio    = idx[3] ? nx_cur_prio : nx_old_prio;
    end

    assign enabled = ~control[4] & dbg_enabled;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_px    <= '0;
            old_px    <= '0;
            cur_pal   <= '0;
            old_pal   <= '0;
            cur_prio  <= '0;
            old_prio  <= '0;
            fine      <= '0;
            cnt       <= '0;
            color_out <= '0;
            prio_out  <= 1'b0;
        end else begin
            if (fire) begin
                cur_px   <= nx_cur_px;
                old_px   <= nx_old_px;
                cur_pal  <= nx_cur_pal;
                old_pal  <= nx_old_pal;
                cur_prio <= nx_cur_prio;
                old_prio <= nx_old_prio;
                fine     <= nx_fine;
            end
            if (ce_pix) begin
                cnt       <= cnt_use + 3'd1;
                color_out <= enabled ? {pal, pix} : 11'd0;
                prio_out  <= enabled & ((prio[0] & pix[3]) | (prio[1] & (|pix)));
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) underrun <= 1'b0;
        else if (abort | swap_under) underrun <= 1'b1;
    end

`ifdef GA23_LAYER_UNDERRUN_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) underrun_cnt <= '0;
        else if ((abort | swap_under) && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
    end
`endif

    wire unused_ok = &{1'b0, control[7], control[5], control[3], attrib[14:11],
                       addr_ext[ADDR_W+23:ADDR_W]};

endmodule

// File: tb/tb_ga23_layer_ext.sv
// Directed bench for ga23_layer_ext: an 8x8 instance drives the pixel checks, a 16x16 instance shares its inputs.
module tb_ga23_layer_ext;

    logic        clk = 1'b0;
    logic        reset_n, ce_pix, load, sdr_rdy, dbg_enabled;
    logic [9:0]  x_ofs, y_ofs, x_base, y, rowscroll;
    logic [7:0]  control;
    logic [15:0] attrib, index;
    logic [31:0] sdr_data;
    logic [14:0] vram_addr, vram_addr16;
    logic [23:0] sdr_addr, sdr_addr16;
    logic        sdr_req, sdr_req16, prio_out, prio_out16, underrun, underrun16;
    logic [10:0] color_out, color_out16;
`ifdef GA23_LAYER_UNDERRUN_CNT_EN
    logic [15:0] ucnt, ucnt16;
`endif

    always #5 clk = ~clk;

    ga23_layer_ext #(.TILE_16(0), .ADDR_W(24)) u_dut (
        .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .load(load),
        .x_ofs(x_ofs), .y_ofs(y_ofs), .control(control), .x_base(x_base), .y(y),
        .rowscroll(rowscroll), .vram_addr(vram_addr), .attrib(attrib), .index(index),
        .sdr_addr(sdr_addr), .sdr_req(sdr_req), .sdr_rdy(sdr_rdy), .sdr_data(sdr_data),
        .color_out(color_out), .prio_out(prio_out), .underrun(underrun),
`ifdef GA23_LAYER_UNDERRUN_CNT_EN
        .underrun_cnt(ucnt),
`endif
        .dbg_enabled(dbg_enabled)
    );

    ga23_layer_ext #(.TILE_16(1), .ADDR_W(24)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .load(load),
        .x_ofs(x_ofs), .y_ofs(y_ofs), .control(control), .x_base(x_base), .y(y),
        .rowscroll(rowscroll), .vram_addr(vram_addr16), .attrib(attrib), .index(index),
        .sdr_addr(sdr_addr16), .sdr_req(sdr_req16), .sdr_rdy(sdr_rdy), .sdr_data(sdr_data),
        .color_out(color_out16), .prio_out(prio_out16), .underrun(underrun16),
`ifdef GA23_LAYER_UNDERRUN_CNT_EN
        .underrun_cnt(ucnt16),
`endif
        .dbg_enabled(dbg_enabled)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    logic [10:0] t_col[8];
    logic        t_prio[8];
    logic        t_req[8];
    logic [23:0] t_addr, t_addr16;

    // One tile column: load on the first pixel, optional sdr_rdy at pixel rdy_at
    task automatic run_tile(input logic [31:0] data, input int rdy_at);
        for (int k = 0; k < 8; k++) begin
            load     = (k == 0);
            sdr_rdy  = (k == rdy_at);
            sdr_data = data;
            @(posedge clk);
            #1;
            t_col[k]  = color_out;
            t_prio[k] = prio_out;
            t_req[k]  = sdr_req;
            if (k == 0) begin
                t_addr   = sdr_addr;
                t_addr16 = sdr_addr16;
            end
        end
        load    = 1'b0;
        sdr_rdy = 1'b0;
    endtask

    localparam logic [31:0] D = 32'h7654_3210;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; ce_pix = 1'b0; load = 1'b0; sdr_rdy = 1'b0; sdr_data = '0;
        dbg_enabled = 1'b1; x_ofs = '0; y_ofs = '0; x_base = '0; y = 10'd5;
        rowscroll = '0; control = '0; attrib = '0; index = 16'h0123;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(sdr_req), 32'd0);
        check("rst_addr", 32'(sdr_addr), 32'd0);
        check("rst_col", 32'(color_out), 32'd0);
        check("rst_prio", 32'(prio_out), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
`ifdef GA23_LAYER_UNDERRUN_CNT_EN
        check("rst_ucnt", 32'(ucnt), 32'd0);
`endif
        reset_n = 1'b1;
        ce_pix  = 1'b1;

        // Tilemap addressing: x=0x2A8, yy=0x45, bank 1
        control = 8'h01; x_base = 10'h2A8; y = 10'h035; y_ofs = 10'h010;
        #1;
        check("vram8", 32'(vram_addr), 32'h2215);
        check("vram16", 32'(vram_addr16), 32'h212A);
        control = 8'h05;
        #1;
        check("vram8_wide", 32'(vram_addr), 32'h2475);
        check("vram16_wide", 32'(vram_addr16), 32'h224A);
        control = 8'h41; rowscroll = 10'd8;
        #1;
        check("vram8_rowscroll", 32'(vram_addr), 32'h2216);
        control = '0; x_base = '0; y = 10'd5; y_ofs = '0; rowscroll = '0;

        // R1: empty window, fetch F1 (flip_y, palette 5)
        attrib = 16'h8405; x_base = 10'd0;
        run_tile(D, 3);
        check("r1_req_pulse", 32'(t_req[0]), 32'd1);
        check("r1_req_drop", 32'(t_req[1]), 32'd0);
        check("r1_addr", 32'(t_addr), 32'h20_2468);
        check("r1_col", 32'(t_col[3]), 32'd0);
        check("r1_underrun", 32'(underrun), 32'd1);
`ifdef GA23_LAYER_UNDERRUN_CNT_EN
        check("r1_ucnt", 32'(ucnt), 32'd1);
`endif

        // R2: show F1; fetch F2 with flip_x, palette 6, fine 3, x[3]=1
        attrib = 16'h8606; x_base = 10'd11;
        run_tile(D, 3);
        for (int k = 0; k < 8; k++)
            check($sformatf("r2_col%0d", k), 32'(t_col[k]), 32'h050 + 32'(k));
        check("r2_prio", 32'(t_prio[7]), 32'd0);
        check("r2_addr16", 32'(t_addr16), 32'h80_91C8);

        // R3: show F2; fetch F3 with prio 01, palette 1
        attrib = 16'h0081; x_base = 10'd0;
        run_tile(32'h0000_0078, 3);
        begin
            logic [10:0] exp_r3[8];
            exp_r3 = '{11'h055, 11'h056, 11'h057, 11'h067, 11'h066, 11'h065, 11'h064, 11'h063};
            for (int k = 0; k < 8; k++)
                check($sformatf("r3_col%0d", k), 32'(t_col[k]), 32'(exp_r3[k]));
        end

        // R4: show F3; fetch F4 with prio 10, palette 2
        attrib = 16'h0102;
        run_tile(32'h0000_00F0, 3);
        check("r4_col0", 32'(t_col[0]), 32'h018);
        check("r4_prio_p8", 32'(t_prio[0]), 32'd1);
        check("r4_col1", 32'(t_col[1]), 32'h017);
        check("r4_prio_p7", 32'(t_prio[1]), 32'd0);
        check("r4_col2", 32'(t_col[2]), 32'h010);

        // R5: show F4; fetch F5 whose data never arrives
        attrib = 16'h8405;
        run_tile(D, -1);
        check("r5_col0", 32'(t_col[0]), 32'h020);
        check("r5_prio_p0", 32'(t_prio[0]), 32'd0);
        check("r5_col1", 32'(t_col[1]), 32'h02F);
        check("r5_prio_pf", 32'(t_prio[1]), 32'd1);

        // R6: F5 aborted, transparent tile; fetch F6 with prio 11, palette 5
        attrib = 16'h0185;
        run_tile(32'hFEDC_BA98, 3);
        check("r6_col0", 32'(t_col[0]), 32'd0);
        check("r6_col4", 32'(t_col[4]), 32'd0);
        check("r6_underrun", 32'(underrun), 32'd1);
`ifdef GA23_LAYER_UNDERRUN_CNT_EN
        check("r6_ucnt", 32'(ucnt), 32'd2);
`endif

        // R7: layer disabled while F6 is shown; fetch F7 (palette 3) still runs
        attrib = 16'h0003; control = 8'h10;
        run_tile(D, 3);
        check("r7_col_off", 32'(t_col[1]), 32'd0);
        check("r7_prio_off", 32'(t_prio[1]), 32'd0);
        check("r7_req", 32'(t_req[0]), 32'd1);

        // R8: show F7; fetch F8 (palette 4) held until the next load
        attrib = 16'h0004; control = 8'h00;
        run_tile(D, -1);
        check("r8_col2", 32'(t_col[2]), 32'h032);

        // R9: F8 data arrives in the same clk as the load
        run_tile(D, 0);
        check("r9_col0", 32'(t_col[0]), 32'h040);
        check("r9_col7", 32'(t_col[7]), 32'h047);
`ifdef GA23_LAYER_UNDERRUN_CNT_EN
        check("r9_ucnt", 32'(ucnt), 32'd2);
`endif

        // Reset while F9 waits for data, then deliver its stale sdr_rdy
        #2;
        reset_n = 1'b0;
        #1;
        check("rstw_req", 32'(sdr_req), 32'd0);
        check("rstw_addr", 32'(sdr_addr), 32'd0);
        check("rstw_col", 32'(color_out), 32'd0);
        check("rstw_underrun", 32'(underrun), 32'd0);
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        sdr_rdy  = 1'b1;
        sdr_data = D;
        @(posedge clk);
        #1;
        sdr_rdy = 1'b0;
        run_tile(D, -1);
        check("stale_underrun", 32'(underrun), 32'd1);
        check("stale_col1", 32'(t_col[1]), 32'd0);
`ifdef GA23_LAYER_UNDERRUN_CNT_EN
        check("stale_ucnt", 32'(ucnt), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
